// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: Ssrc/LWSrc codes, FSM states and
// the access-size helpers used for lane steering.
package lsu_pkg;

  localparam logic [1:0] SSRC_SB = 2'b00;
  localparam logic [1:0] SSRC_SH = 2'b01;
  localparam logic [1:0] SSRC_SW = 2'b10;

  localparam logic [2:0] LW_LB  = 3'b000;
  localparam logic [2:0] LW_LH  = 3'b001;
  localparam logic [2:0] LW_LW  = 3'b010;
  localparam logic [2:0] LW_LBU = 3'b100;
  localparam logic [2:0] LW_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } lsu_size_e;

  // Unknown width codes fall back to a full word access.
  function automatic lsu_size_e access_size(logic st, logic [1:0] ssrc, logic [2:0] lwsrc);
    lsu_size_e s;
    if (st) begin
      case (ssrc)
        SSRC_SB: s = SZ_BYTE;
        SSRC_SH: s = SZ_HALF;
        SSRC_SW: s = SZ_WORD;
        default: s = SZ_WORD;
      endcase
    end else begin
      case (lwsrc)
        LW_LB, LW_LBU: s = SZ_BYTE;
        LW_LH, LW_LHU: s = SZ_HALF;
        default:       s = SZ_WORD;
      endcase
    end
    return s;
  endfunction

  function automatic logic misaligned(lsu_size_e s, logic [1:0] lo);
    logic m;
    case (s)
      SZ_HALF: m = lo[0];
      SZ_WORD: m = (lo != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] lane_align(lsu_size_e s, logic [1:0] lo);
    logic [1:0] l;
    case (s)
      SZ_HALF: l = {lo[1], 1'b0};
      SZ_WORD: l = 2'b00;
      default: l = lo;
    endcase
    return l;
  endfunction

  function automatic logic [3:0] byte_enables(lsu_size_e s, logic [1:0] lo);
    logic [3:0] be;
    case (s)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_replicate(lsu_size_e s, logic [31:0] w);
    logic [31:0] r;
    case (s)
      SZ_BYTE: r = {4{w[7:0]}};
      SZ_HALF: r = {2{w[15:0]}};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_if;
  // Handshake: mem_req with mem_we/mem_addr/mem_be/mem_wdata is held stable
  // until mem_gnt is seen in the same cycle; the request is accepted on that
  // cycle. A load's word returns later on mem_rdata, qualified by mem_rvalid.
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it
// according to the load type.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  lane,
  input  logic [2:0]  lwsrc,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (lane)
      2'd0: byte_sel = data[7:0];
      2'd1: byte_sel = data[15:8];
      2'd2: byte_sel = data[23:16];
      2'd3: byte_sel = data[31:24];
      default: byte_sel = data[7:0];
    endcase
    half_sel = lane[1] ? data[31:16] : data[15:0];
  end

  always_comb begin
    ext = data;
    case (lwsrc)
      LW_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
      LW_LBU:  ext = {24'h000000, byte_sel};
      LW_LH:   ext = {{16{half_sel[15]}}, half_sel};
      LW_LHU:  ext = {16'h0000, half_sel};
      LW_LW:   ext = data;
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: issues byte-enabled requests and returns extended
// load data. Optional misalignment trap: define LSU_MISALIGN_CHECK_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ls_valid,
  input  logic        is_store,
  input  logic [1:0]  Ssrc,
  input  logic [2:0]  LWSrc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        bus_err,
  output logic        misalign,
  lsu_if.master       mem,
  output lsu_state_e  dbg_state
);

  localparam logic [7:0] TMR_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state;
  logic [7:0]  tmr;
  logic [1:0]  lane_q;
  logic [2:0]  lwsrc_q;
  logic        store_q;
  logic [31:0] ext_data;

  lsu_size_e   size;
  logic [1:0]  lane_next;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic        expired;

  assign size       = access_size(is_store, Ssrc, LWSrc);
  assign lane_next  = lane_align(size, addr[1:0]);
  assign be_next    = byte_enables(size, lane_next);
  assign wdata_next = store_replicate(size, wdata);
  assign expired    = (tmr == TMR_LAST);

  assign stall     = ls_valid & ~done;
  assign dbg_state = state;

`ifdef LSU_MISALIGN_CHECK_EN
  logic misalign_q;
  logic bad_align;
  assign bad_align = misaligned(size, addr[1:0]);
  assign misalign  = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  lsu_load_extend u_extend (
    .data  (mem.mem_rdata),
    .lane  (lane_q),
    .lwsrc (lwsrc_q),
    .ext   (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      tmr           <= 8'd0;
      lane_q        <= 2'b00;
      lwsrc_q       <= 3'b000;
      store_q       <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 32'h0;
      mem.mem_be    <= 4'h0;
      mem.mem_wdata <= 32'h0;
      done          <= 1'b0;
      bus_err       <= 1'b0;
      rdata         <= 32'h0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      bus_err <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (ls_valid) begin
            lane_q  <= lane_next;
            lwsrc_q <= LWSrc;
            store_q <= is_store;
            tmr     <= 8'd0;
`ifdef LSU_MISALIGN_CHECK_EN
            if (bad_align) begin
              state      <= ST_DONE;
              done       <= 1'b1;
              misalign_q <= 1'b1;
              rdata      <= 32'h0;
            end else
`endif
            begin
              state         <= ST_REQ;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= is_store;
              mem.mem_addr  <= {addr[31:2], 2'b00};
              mem.mem_be    <= be_next;
              mem.mem_wdata <= wdata_next;
            end
          end
        end

        // A grant in the expiry cycle still completes the access.
        ST_REQ: begin
          if (mem.mem_gnt) begin
            mem.mem_req <= 1'b0;
            tmr         <= 8'd0;
            if (store_q) begin
              state <= ST_DONE;
              done  <= 1'b1;
              rdata <= 32'h0;
            end else begin
              state <= ST_RESP;
            end
          end else if (expired) begin
            mem.mem_req <= 1'b0;
            state       <= ST_DONE;
            done        <= 1'b1;
            bus_err     <= 1'b1;
            rdata       <= 32'h0;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end

        ST_RESP: begin
          if (mem.mem_rvalid) begin
            state <= ST_DONE;
            done  <= 1'b1;
            rdata <= ext_data;
          end else if (expired) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            bus_err <= 1'b1;
            rdata   <= 32'h0;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end

        // ls_valid seen here belongs to the next instruction; IDLE samples it.
        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a spec-level reference model and a
// per-cycle compare process.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ls_valid = 1'b0;
  logic        is_store = 1'b0;
  logic [1:0]  ssrc = 2'b00;
  logic [2:0]  lwsrc = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall, done, bus_err, misalign;
  logic [31:0] rdata;
  lsu_state_e  dbg_state;

  lsu_if mem_bus ();

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ls_valid  (ls_valid),
    .is_store  (is_store),
    .Ssrc      (ssrc),
    .LWSrc     (lwsrc),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .done      (done),
    .rdata     (rdata),
    .bus_err   (bus_err),
    .misalign  (misalign),
    .mem       (mem_bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int m_size(bit st, logic [1:0] ss, logic [2:0] lw);
    if (st) return (ss == 2'b00) ? 1 : (ss == 2'b01) ? 2 : 4;
    if (lw == 3'b000 || lw == 3'b100) return 1;
    if (lw == 3'b001 || lw == 3'b101) return 2;
    return 4;
  endfunction

  function automatic int m_lane(logic [31:0] a, int sz);
    int lo;
    lo = int'(a[1:0]);
    return lo - (lo % sz);
  endfunction

  function automatic bit m_mis(logic [31:0] a, int sz);
`ifdef LSU_MISALIGN_CHECK_EN
    return (int'(a[1:0]) % sz) != 0;
`else
    return (int'(a[1:0]) % sz) != (int'(a[1:0]) % sz);
`endif
  endfunction

  function automatic logic [3:0] m_be(int sz, int lane);
    return 4'(((1 << sz) - 1) << lane);
  endfunction

  function automatic logic [31:0] m_wdata(int sz, logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] lw, int sz, int lane, logic [31:0] w);
    logic [31:0] v;
    v = w >> (8 * lane);
    if (sz == 1) begin
      v = v & 32'h000000FF;
      if (lw == 3'b000 && v[7]) v = v | 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = v & 32'h0000FFFF;
      if (lw == 3'b001 && v[15]) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  // A response later than T waiting cycles (or never) is a bus error.
  function automatic bit m_timeout(bit st, int gd, int rd);
    if (gd < 0 || gd >= T) return 1'b1;
    if (!st && (rd < 0 || rd >= T)) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- scoreboard ----------------
  // entry: {check_rdata, misalign, bus_err, rdata}
  logic [34:0] exp_q[$];
  logic [34:0] cmp_e;
  logic        req_we_e;
  logic [31:0] req_addr_e;
  logic [3:0]  req_be_e;
  logic [31:0] req_wd_e;

  always @(negedge clk) begin
    if (rst_n) begin
      check("stall", 32'(stall), 32'(ls_valid & ~done));
      if (mem_bus.mem_req) begin
        check("mem_we", 32'(mem_bus.mem_we), 32'(req_we_e));
        check("mem_addr", mem_bus.mem_addr, req_addr_e);
        check("mem_be", 32'(mem_bus.mem_be), 32'(req_be_e));
        if (req_we_e) check("mem_wdata", mem_bus.mem_wdata, req_wd_e);
      end
      if (done) begin
        check("req_low_at_done", 32'(mem_bus.mem_req), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL done_unexpected: got done=1 expected done=0");
        end else begin
          cmp_e = exp_q.pop_front();
          check("misalign", 32'(misalign), 32'(cmp_e[33]));
          check("bus_err", 32'(bus_err), 32'(cmp_e[32]));
          if (cmp_e[34]) check("rdata", rdata, cmp_e[31:0]);
        end
      end else begin
        check("pulse_without_done", 32'({bus_err, misalign}), 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_access(input bit st, input logic [1:0] ss, input logic [2:0] lw,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
                           input int gd, input int rd, input bit tie,
                           output int lat, output int reqs, output logic [3:0] be0,
                           output logic [31:0] addr0, output logic [31:0] wd0,
                           output logic [31:0] rdo, output bit berr_o, output bit mis_o);
    int sz, lane, resp_n;
    bit mis, to, granted;
    sz   = m_size(st, ss, lw);
    lane = m_lane(a, sz);
    mis  = m_mis(a, sz);
    to   = !mis && m_timeout(st, gd, rd);
    req_we_e   = st;
    req_addr_e = {a[31:2], 2'b00};
    req_be_e   = m_be(sz, lane);
    req_wd_e   = m_wdata(sz, wd);
    exp_q.push_back({(!st || mis || to), mis, to,
                     ((mis || to || st) ? 32'h0 : m_load(lw, sz, lane, rword))});

    @(posedge clk); #1;
    ls_valid = 1'b1; is_store = st; ssrc = ss; lwsrc = lw; addr = a; wdata = wd;
    mem_bus.mem_rdata = rword; mem_bus.mem_gnt = tie; mem_bus.mem_rvalid = 1'b0;
    lat = -1; reqs = 0; granted = 1'b0; resp_n = 0;
    be0 = 4'h0; addr0 = 32'h0; wd0 = 32'h0; rdo = 32'h0; berr_o = 1'b0; mis_o = 1'b0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c; rdo = rdata; berr_o = bus_err; mis_o = misalign;
        mem_bus.mem_rvalid = 1'b0; mem_bus.mem_gnt = tie;
      end else if (mem_bus.mem_req) begin
        if (reqs == 0) begin
          be0 = mem_bus.mem_be; addr0 = mem_bus.mem_addr; wd0 = mem_bus.mem_wdata;
        end
        mem_bus.mem_gnt = tie || (reqs == gd);
        if (mem_bus.mem_gnt) granted = 1'b1;
        reqs++;
      end else begin
        mem_bus.mem_gnt = tie;
        if (granted && !st) begin
          mem_bus.mem_rvalid = (resp_n == rd);
          resp_n++;
        end
      end
    end
    if (lat < 0) begin
      n_checks++;
      $display("FAIL done_wait: got no done in 40 cycles expected done");
      exp_q.delete();
    end
    @(posedge clk); #1;
    ls_valid = 1'b0; mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  int          lat, reqs, dones;
  logic [3:0]  be0;
  logic [31:0] addr0, wd0, rdo;
  bit          berr_o, mis_o;

  initial begin
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_bus.mem_we), 32'd0);
    check("rst_mem_be", 32'(mem_bus.mem_be), 32'd0);
    check("rst_mem_addr", mem_bus.mem_addr, 32'd0);
    check("rst_mem_wdata", mem_bus.mem_wdata, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_flags", 32'({bus_err, misalign}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // SB at 0x1003, gnt tied high
    do_access(1, 2'b00, 3'b000, 32'h1003, 32'h000000A5, 32'h0, 0, 0, 1,
              lat, reqs, be0, addr0, wd0, rdo, berr_o, mis_o);
    check("sb_latency", 32'(lat), 32'd2);
    check("sb_be", 32'(be0), 32'h8);
    check("sb_addr", addr0, 32'h1000);
    check("sb_wdata", wd0, 32'hA5A5A5A5);

    // LB / LBU at 0x2001
    do_access(0, 2'b00, 3'b000, 32'h2001, 32'h0, 32'h1234F0CC, 0, 0, 0,
              lat, reqs, be0, addr0, wd0, rdo, berr_o, mis_o);
    check("lb_latency", 32'(lat), 32'd3);
    check("lb_rdata", rdo, 32'hFFFFFFF0);
    do_access(0, 2'b00, 3'b100, 32'h2001, 32'h0, 32'h1234F0CC, 0, 0, 0,
              lat, reqs, be0, addr0, wd0, rdo, berr_o, mis_o);
    check("lbu_rdata", rdo, 32'h000000F0);

    // LHU at 0x2002, gnt on the 4th REQ cycle (same cycle as expiry)
    do_access(0, 2'b00, 3'b101, 32'h2002, 32'h0, 32'h80017FFF, 3, 0, 0,
              lat, reqs, be0, addr0, wd0, rdo, berr_o, mis_o);
    check("lhu_req_cycles", 32'(reqs), 32'd4);
    check("lhu_latency", 32'(lat), 32'd6);
    check("lhu_rdata", rdo, 32'h00008001);
    check("lhu_no_err", 32'(berr_o), 32'd0);

    // LW, gnt never: bus error
    do_access(0, 2'b00, 3'b010, 32'h2000, 32'h0, 32'h55AA55AA, -1, 0, 0,
              lat, reqs, be0, addr0, wd0, rdo, berr_o, mis_o);
    check("gnt_to_latency", 32'(lat), 32'd5);
    check("gnt_to_bus_err", 32'(berr_o), 32'd1);
    check("gnt_to_rdata", rdo, 32'h0);
    check("gnt_to_req_after", 32'(mem_bus.mem_req), 32'd0);

    // LW, rvalid never: bus error from RESP
    do_access(0, 2'b00, 3'b010, 32'h4000, 32'h0, 32'hDEADBEEF, 0, -1, 0,
              lat, reqs, be0, addr0, wd0, rdo, berr_o, mis_o);
    check("rv_to_latency", 32'(lat), 32'd6);
    check("rv_to_bus_err", 32'(berr_o), 32'd1);

    // LW, rvalid in the expiry cycle completes normally
    do_access(0, 2'b00, 3'b010, 32'h4000, 32'h0, 32'hDEADBEEF, 0, 3, 0,
              lat, reqs, be0, addr0, wd0, rdo, berr_o, mis_o);
    check("rv_tie_latency", 32'(lat), 32'd6);
    check("rv_tie_rdata", rdo, 32'hDEADBEEF);
    check("rv_tie_no_err", 32'(berr_o), 32'd0);

    // SW at 0x3002
    do_access(1, 2'b10, 3'b000, 32'h3002, 32'h11223344, 32'h0, 0, 0, 1,
              lat, reqs, be0, addr0, wd0, rdo, berr_o, mis_o);
`ifdef LSU_MISALIGN_CHECK_EN
    check("sw_mis_latency", 32'(lat), 32'd1);
    check("sw_mis_flag", 32'(mis_o), 32'd1);
    check("sw_mis_no_req", 32'(reqs), 32'd0);
`else
    check("sw_latency", 32'(lat), 32'd2);
    check("sw_be", 32'(be0), 32'hF);
    check("sw_addr", addr0, 32'h3000);
    check("sw_wdata", wd0, 32'h11223344);
`endif

    // LH at 0x2003
    do_access(0, 2'b00, 3'b001, 32'h2003, 32'h0, 32'h80017FFF, 0, 0, 0,
              lat, reqs, be0, addr0, wd0, rdo, berr_o, mis_o);
`ifdef LSU_MISALIGN_CHECK_EN
    check("lh_mis_latency", 32'(lat), 32'd1);
    check("lh_mis_rdata", rdo, 32'h0);
`else
    check("lh_latency", 32'(lat), 32'd3);
    check("lh_be", 32'(be0), 32'hC);
    check("lh_rdata", rdo, 32'hFFFF8001);
`endif

    // SH upper half, Ssrc=11 as SW, LWSrc=111 as LW, LB lanes 3 and 0
    do_access(1, 2'b01, 3'b000, 32'h0012, 32'hBEEF1234, 32'h0, 0, 0, 1,
              lat, reqs, be0, addr0, wd0, rdo, berr_o, mis_o);
    check("sh_be", 32'(be0), 32'hC);
    check("sh_wdata", wd0, 32'h12341234);
    check("sh_addr", addr0, 32'h0010);
    do_access(1, 2'b11, 3'b000, 32'h6004, 32'hCAFEF00D, 32'h0, 0, 0, 1,
              lat, reqs, be0, addr0, wd0, rdo, berr_o, mis_o);
    check("s11_be", 32'(be0), 32'hF);
    check("s11_wdata", wd0, 32'hCAFEF00D);
    do_access(0, 2'b00, 3'b111, 32'h5000, 32'h0, 32'h80000001, 1, 1, 0,
              lat, reqs, be0, addr0, wd0, rdo, berr_o, mis_o);
    check("l111_latency", 32'(lat), 32'd5);
    check("l111_rdata", rdo, 32'h80000001);
    do_access(0, 2'b00, 3'b000, 32'h7003, 32'h0, 32'h80112233, 0, 0, 0,
              lat, reqs, be0, addr0, wd0, rdo, berr_o, mis_o);
    check("lb3_rdata", rdo, 32'hFFFFFF80);
    do_access(0, 2'b00, 3'b000, 32'h7000, 32'h0, 32'h80112233, 0, 0, 0,
              lat, reqs, be0, addr0, wd0, rdo, berr_o, mis_o);
    check("lb0_rdata", rdo, 32'h00000033);

    // Reset while waiting in RESP; a late rvalid must not retire anything
    req_we_e = 1'b0; req_addr_e = 32'h8000; req_be_e = 4'hF;
    @(posedge clk); #1;
    ls_valid = 1'b1; is_store = 1'b0; lwsrc = 3'b010; addr = 32'h8000; mem_bus.mem_gnt = 1'b1;
    @(posedge clk); #1;
    check("rstmid_req", 32'(mem_bus.mem_req), 32'd1);
    @(posedge clk); #1;
    check("rstmid_in_resp", 32'(dbg_state), 32'(ST_RESP));
    mem_bus.mem_gnt = 1'b0;
    #2;
    rst_n = 1'b0; ls_valid = 1'b0;
    #1;
    check("rstmid_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rstmid_req_low", 32'(mem_bus.mem_req), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    mem_bus.mem_rvalid = 1'b1;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    mem_bus.mem_rvalid = 1'b0;
    check("rstmid_no_done", 32'(dones), 32'd0);
    check("rstmid_idle_after", 32'(dbg_state), 32'(ST_IDLE));

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
